// File: rtl/gpu_rect_pkg.sv
// Shared types for the rectangle hit scanner: default widths, rectangle layout, FSM states.
package gpu_rect_pkg;

    localparam int DEF_COORD_WIDTH = 16;
    localparam int DEF_COLOR_WIDTH = 16;

    typedef struct packed {
        logic [DEF_COORD_WIDTH-1:0] left;
        logic [DEF_COORD_WIDTH-1:0] top;
        logic [DEF_COORD_WIDTH-1:0] right;
        logic [DEF_COORD_WIDTH-1:0] bottom;
        logic [DEF_COLOR_WIDTH-1:0] color;
    } rect_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rect_point_test.sv
// Half-open point-in-rectangle test; a degenerate rectangle can never contain a point.
module rect_point_test
    import gpu_rect_pkg::*;
#(
    parameter int COORD_WIDTH = DEF_COORD_WIDTH
) (
    input  logic [COORD_WIDTH-1:0] left,
    input  logic [COORD_WIDTH-1:0] top,
    input  logic [COORD_WIDTH-1:0] right,
    input  logic [COORD_WIDTH-1:0] bottom,
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    output logic                   hit
);

    assign hit = (x >= left) && (x < right) && (y >= top) && (y < bottom);

endmodule

// File: rtl/rect_hit_scanner.sv
// Multi-rectangle point hit-tester: scans LANES slots per cycle, topmost (highest index) hit wins.
// Optional per-slot visibility mask enabled by defining RECT_HIT_MASK_EN.
module rect_hit_scanner
    import gpu_rect_pkg::*;
#(
    parameter int                     COORD_WIDTH = DEF_COORD_WIDTH,
    parameter int                     COLOR_WIDTH = DEF_COLOR_WIDTH,
    parameter int                     RECT_COUNT  = 16,
    parameter int                     LANES       = 4,
    parameter logic [COLOR_WIDTH-1:0] BG_COLOR    = '0,
    localparam int                    IDX_W       = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_index,
    input  logic [COORD_WIDTH-1:0] wr_left,
    input  logic [COORD_WIDTH-1:0] wr_top,
    input  logic [COORD_WIDTH-1:0] wr_right,
    input  logic [COORD_WIDTH-1:0] wr_bottom,
    input  logic [COLOR_WIDTH-1:0] wr_color,
`ifdef RECT_HIT_MASK_EN
    input  logic                   wr_visible,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COORD_WIDTH-1:0] in_x,
    input  logic [COORD_WIDTH-1:0] in_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_hit,
    output logic [IDX_W-1:0]       out_index,
    output logic [COLOR_WIDTH-1:0] out_color
);

    localparam int GROUPS = RECT_COUNT / LANES;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] left;
        logic [COORD_WIDTH-1:0] top;
        logic [COORD_WIDTH-1:0] right;
        logic [COORD_WIDTH-1:0] bottom;
        logic [COLOR_WIDTH-1:0] color;
    } slot_t;

    slot_t                  rects [RECT_COUNT];
    state_t                 state;
    logic [GRP_W-1:0]       grp;
    logic [COORD_WIDTH-1:0] px, py;
    logic                   best_hit;
    logic [IDX_W-1:0]       best_idx;
    logic [COLOR_WIDTH-1:0] best_color;
    logic [IDX_W-1:0]       lane_slot [LANES];
    logic [LANES-1:0]       lane_raw, lane_hit;
    logic                   grp_hit;
    logic [IDX_W-1:0]       grp_idx;
    logic [COLOR_WIDTH-1:0] grp_color;
    logic                   wr_ok;

    assign in_ready = (state == IDLE) && !reset;
    assign wr_ok    = wr_en && (int'(wr_index) < RECT_COUNT);

    // NOTE: the register file is reset explicitly because an all-zero slot is degenerate,
    // which is what makes a freshly reset scanner report misses everywhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RECT_COUNT; i++) rects[i] <= '0;
        end else if (wr_ok) begin
            rects[wr_index] <= '{left: wr_left, top: wr_top, right: wr_right,
                                 bottom: wr_bottom, color: wr_color};
        end
    end

`ifdef RECT_HIT_MASK_EN
    logic [RECT_COUNT-1:0] visible;

    always_ff @(posedge clk) begin
        if (reset)      visible <= '0;
        else if (wr_ok) visible[wr_index] <= wr_visible;
    end
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_slot[l] = IDX_W'(int'(grp) * LANES + l);

        rect_point_test #(.COORD_WIDTH(COORD_WIDTH)) u_test (
            .left   (rects[lane_slot[l]].left),
            .top    (rects[lane_slot[l]].top),
            .right  (rects[lane_slot[l]].right),
            .bottom (rects[lane_slot[l]].bottom),
            .x      (px),
            .y      (py),
            .hit    (lane_raw[l])
        );

`ifdef RECT_HIT_MASK_EN
        assign lane_hit[l] = lane_raw[l] & visible[lane_slot[l]];
`else
        assign lane_hit[l] = lane_raw[l];
`endif
    end

    // NOTE: defaults first so no path leaves a variable unassigned (no latch), and blocking
    // assignments let a later (higher-index) lane overwrite an earlier one.
    always_comb begin
        grp_hit   = 1'b0;
        grp_idx   = '0;
        grp_color = '0;
        for (int l = 0; l < LANES; l++) begin
            if (lane_hit[l]) begin
                grp_hit   = 1'b1;
                grp_idx   = lane_slot[l];
                grp_color = rects[lane_slot[l]].color;
            end
        end
    end

    // The winner's colour is captured with its index so a later rewrite of that slot cannot leak in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grp        <= '0;
            px         <= '0;
            py         <= '0;
            best_hit   <= 1'b0;
            best_idx   <= '0;
            best_color <= '0;
            out_valid  <= 1'b0;
            out_hit    <= 1'b0;
            out_index  <= '0;
            out_color  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        px         <= in_x;
                        py         <= in_y;
                        best_hit   <= 1'b0;
                        best_idx   <= '0;
                        best_color <= BG_COLOR;
                        grp        <= '0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (grp_hit) begin
                        best_hit   <= 1'b1;
                        best_idx   <= grp_idx;
                        best_color <= grp_color;
                    end
                    if (grp == GRP_W'(GROUPS - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_hit   <= grp_hit | best_hit;
                        out_index <= grp_hit ? grp_idx : best_idx;
                        out_color <= grp_hit ? grp_color : best_color;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
